dt_estimator: RTL

- Upstream stage of `fuzzifier_dT`.
- Takes a stream of signed temperature samples and forms a windowed difference dT = T[n] − T[n−DEPTH] in a circular history buffer.
- Saturates dT to Q7.0 (signed 8-bit) and presents it with a one-cycle valid strobe. `dt` wires directly to the fuzzifier's `x` input.

---
 rtl/dt_estimator.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dt_estimator.sv
// Windowed temperature difference dT = T[n] - T[n-DEPTH], saturated to signed 8 bits.
// Optional feature: define DT_SMOOTH_EN to average each new dT with the previous output.
module dt_estimator #(
    parameter int DEPTH = 4,
    parameter int TW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_valid,
    input  logic [TW-1:0] sample,
    input  logic          clear,
    output logic [7:0]    dt,
    output logic          dt_valid,
    output logic          primed
);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(DEPTH - 1);
    localparam logic signed [TW:0] SAT_MAX = 127;
    localparam logic signed [TW:0] SAT_MIN = -128;

    typedef enum logic {WARMUP, RUN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [7:0]    dt_q, dt_d;
    logic          dt_valid_q, dt_valid_d;
    logic          primed_q, primed_d;
    logic          hist_we;
    logic [TW-1:0] hist_q [DEPTH];

    logic signed [TW:0] raw;
    logic signed [7:0]  sat_raw;
    logic [7:0]         dt_new;
`ifdef DT_SMOOTH_EN
    logic               seed_q, seed_d;
    logic signed [8:0]  smooth_sum;
`endif

    // One extra bit of headroom makes the subtraction overflow-free for any TW.
    always_comb begin
        raw = $signed({sample[TW-1], sample}) -
              $signed({hist_q[wr_ptr_q][TW-1], hist_q[wr_ptr_q]});
        if (raw > SAT_MAX)      sat_raw = 8'sd127;
        else if (raw < SAT_MIN) sat_raw = -8'sd128;
        else                    sat_raw = raw[7:0];
`ifdef DT_SMOOTH_EN
        smooth_sum = $signed({dt_q[7], dt_q}) + $signed({sat_raw[7], sat_raw});
        dt_new     = seed_q ? sat_raw : smooth_sum[8:1];
`else
        dt_new     = sat_raw;
`endif
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        dt_d       = dt_q;
        dt_valid_d = 1'b0;
        hist_we    = 1'b0;
`ifdef DT_SMOOTH_EN
        seed_d     = seed_q;
`endif
        if (clear) begin
            state_d  = WARMUP;
            wr_ptr_d = '0;
            fill_d   = '0;
            dt_d     = '0;
`ifdef DT_SMOOTH_EN
            seed_d   = 1'b1;
`endif
        end else if (sample_valid) begin
            hist_we  = 1'b1;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            case (state_q)
                WARMUP: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_LAST) state_d = RUN;
                end
                RUN: begin
                    dt_d       = dt_new;
                    dt_valid_d = 1'b1;
`ifdef DT_SMOOTH_EN
                    seed_d     = 1'b0;
`endif
                end
                default: state_d = WARMUP;
            endcase
        end
        primed_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WARMUP;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            dt_q       <= '0;
            dt_valid_q <= 1'b0;
            primed_q   <= 1'b0;
`ifdef DT_SMOOTH_EN
            seed_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            dt_q       <= dt_d;
            dt_valid_q <= dt_valid_d;
            primed_q   <= primed_d;
`ifdef DT_SMOOTH_EN
            seed_q     <= seed_d;
`endif
        end
    end

    // History is only read once the window is full, so it carries no reset.
    always_ff @(posedge clk) begin
        if (hist_we) hist_q[wr_ptr_q] <= sample;
    end

    assign dt       = dt_q;
    assign dt_valid = dt_valid_q;
    assign primed   = primed_q;
endmodule
